// File: rtl/contador_de_programa_param.sv
// Fetch-stage program counter. The next PC comes from increment, branch, jump,
// call/return through a circular return-address stack, exception entry, or EPC.
module contador_de_programa_param #(
    parameter int LARGURA       = 26,
    parameter int PASSO         = 1,
    parameter int VETOR_RESET   = 0,
    parameter int VETOR_EXCECAO = 1,
    parameter int PROF_PILHA    = 4
) (
    input  logic               clock,
    input  logic               pc_reset,
    input  logic               habilita,
    input  logic               sel_desvio,
    input  logic [LARGURA-1:0] endereco_desvio,
    input  logic               sel_salto,
    input  logic               chamada,
    input  logic               retorno,
    input  logic [LARGURA-1:0] endereco_salto,
    input  logic               excecao,
    input  logic               retorno_excecao,
    output logic [LARGURA-1:0] pcAtual,
    output logic [LARGURA-1:0] epc,
    output logic               em_excecao,
    output logic               pilha_vazia,
    output logic               pilha_cheia,
    output logic               erro_pilha
);

    localparam int PW = $clog2(PROF_PILHA);
    localparam int CW = PW + 1;
    localparam logic [LARGURA-1:0] PASSO_V = LARGURA'(PASSO);
    localparam logic [LARGURA-1:0] RESET_V = LARGURA'(VETOR_RESET);
    localparam logic [LARGURA-1:0] EXC_V   = LARGURA'(VETOR_EXCECAO);
    localparam logic [CW-1:0]      CHEIO   = CW'(PROF_PILHA);

    logic [LARGURA-1:0] pc_q, pc_d;
    logic [LARGURA-1:0] epc_q, epc_d;
    logic               em_exc_q, em_exc_d;
    logic               erro_q, erro_d;
    logic [PW-1:0]      topo_q, topo_d;
    logic [CW-1:0]      cont_q, cont_d;
    logic [LARGURA-1:0] seq;
    logic [PW-1:0]      pos_push;
    logic               empilha;

    logic [LARGURA-1:0] pilha [PROF_PILHA];

    assign seq      = pc_q + PASSO_V;
    assign pos_push = topo_q + PW'(1);

    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        em_exc_d = em_exc_q;
        erro_d   = erro_q;
        topo_d   = topo_q;
        cont_d   = cont_q;
        empilha  = 1'b0;
        if (excecao) begin
            pc_d = EXC_V;
            // No nesting: a second exception keeps the original return point.
            if (!em_exc_q) begin
                epc_d    = pc_q;
                em_exc_d = 1'b1;
            end
        end else if (!habilita) begin
            pc_d = pc_q;
        end else if (retorno_excecao && em_exc_q) begin
            pc_d     = epc_q;
            em_exc_d = 1'b0;
        end else if (retorno) begin
            if (cont_q != '0) begin
                pc_d   = pilha[topo_q];
                topo_d = topo_q - PW'(1);
                cont_d = cont_q - CW'(1);
            end else begin
                pc_d   = seq;
                erro_d = 1'b1;
            end
        end else if (chamada) begin
            // When full, writing at top+1 lands on the oldest entry.
            empilha = 1'b1;
            topo_d  = pos_push;
            pc_d    = endereco_salto;
            if (cont_q == CHEIO) begin
                erro_d = 1'b1;
            end else begin
                cont_d = cont_q + CW'(1);
            end
        end else if (sel_salto) begin
            pc_d = endereco_salto;
        end else if (sel_desvio) begin
            pc_d = endereco_desvio;
        end else begin
            pc_d = seq;
        end
    end

    always_ff @(posedge clock or posedge pc_reset) begin
        if (pc_reset) begin
            pc_q     <= RESET_V;
            epc_q    <= '0;
            em_exc_q <= 1'b0;
            erro_q   <= 1'b0;
            topo_q   <= '0;
            cont_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            em_exc_q <= em_exc_d;
            erro_q   <= erro_d;
            topo_q   <= topo_d;
            cont_q   <= cont_d;
        end
    end

    // Stack storage is not reset; only the count defines valid entries.
    always_ff @(posedge clock) begin
        if (empilha && !pc_reset) begin
            pilha[pos_push] <= seq;
        end
    end

    assign pcAtual     = pc_q;
    assign epc         = epc_q;
    assign em_excecao  = em_exc_q;
    assign erro_pilha  = erro_q;
    assign pilha_vazia = (cont_q == '0);
    assign pilha_cheia = (cont_q == CHEIO);

endmodule

// File: tb/tb_contador_de_programa_param.sv
// Bench for contador_de_programa_param: directed vector table plus randomized
// cycles against a queue-based reference, on a 26-bit and an 8-bit instance.
module tb_contador_de_programa_param;

    localparam int W  = 26;
    localparam int W8 = 8;
    localparam logic [31:0] MASK = (32'h1 << W) - 32'h1;

    logic          clock = 1'b0;
    logic          pc_reset, habilita, sel_desvio, sel_salto, chamada, retorno;
    logic          excecao, retorno_excecao;
    logic [W-1:0]  endereco_desvio, endereco_salto;
    logic [W-1:0]  pc_a, epc_a;
    logic          emx_a, vaz_a, chei_a, err_a;
    logic [W8-1:0] pc_b, epc_b;
    logic          emx_b, vaz_b, chei_b, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    contador_de_programa_param #(.LARGURA(W)) dut (
        .clock(clock), .pc_reset(pc_reset), .habilita(habilita),
        .sel_desvio(sel_desvio), .endereco_desvio(endereco_desvio),
        .sel_salto(sel_salto), .chamada(chamada), .retorno(retorno),
        .endereco_salto(endereco_salto), .excecao(excecao),
        .retorno_excecao(retorno_excecao), .pcAtual(pc_a), .epc(epc_a),
        .em_excecao(emx_a), .pilha_vazia(vaz_a), .pilha_cheia(chei_a),
        .erro_pilha(err_a)
    );

    contador_de_programa_param #(.LARGURA(W8)) dut8 (
        .clock(clock), .pc_reset(pc_reset), .habilita(habilita),
        .sel_desvio(sel_desvio), .endereco_desvio(endereco_desvio[W8-1:0]),
        .sel_salto(sel_salto), .chamada(chamada), .retorno(retorno),
        .endereco_salto(endereco_salto[W8-1:0]), .excecao(excecao),
        .retorno_excecao(retorno_excecao), .pcAtual(pc_b), .epc(epc_b),
        .em_excecao(emx_b), .pilha_vazia(vaz_b), .pilha_cheia(chei_b),
        .erro_pilha(err_b)
    );

    // Reference state: the stack is a plain queue, newest entry at the back.
    logic [31:0] m_pc, m_epc;
    logic        m_emx, m_err;
    logic [31:0] m_stk[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_epc = 0; m_emx = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic model_step();
        logic [31:0] seq;
        seq = (m_pc + 1) & MASK;
        if (excecao) begin
            if (!m_emx) begin
                m_epc = m_pc;
                m_emx = 1;
            end
            m_pc = 1;
        end else if (!habilita) begin
            m_pc = m_pc;
        end else if (retorno_excecao && m_emx) begin
            m_pc  = m_epc;
            m_emx = 0;
        end else if (retorno) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = seq;
                m_err = 1;
            end
        end else if (chamada) begin
            if (m_stk.size() == 4) begin
                void'(m_stk.pop_front());
                m_err = 1;
            end
            m_stk.push_back(seq);
            m_pc = 32'(endereco_salto);
        end else if (sel_salto) m_pc = 32'(endereco_salto);
        else if (sel_desvio)    m_pc = 32'(endereco_desvio);
        else                    m_pc = seq;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"},    32'(pc_a), m_pc);
        chk({tag, " pc8"},   32'(pc_b), m_pc & 32'hFF);
        chk({tag, " epc"},   32'(epc_a), m_epc);
        chk({tag, " epc8"},  32'(epc_b), m_epc & 32'hFF);
        chk({tag, " emx"},   32'(emx_a), 32'(m_emx));
        chk({tag, " vazia"}, 32'(vaz_a), 32'(m_stk.size() == 0));
        chk({tag, " cheia"}, 32'(chei_a), 32'(m_stk.size() == 4));
        chk({tag, " erro"},  32'(err_a), 32'(m_err));
        chk({tag, " erro8"}, 32'(err_b), 32'(m_err));
    endtask

    task automatic clear_inputs();
        habilita = 1; sel_desvio = 0; sel_salto = 0; chamada = 0; retorno = 0;
        excecao = 0; retorno_excecao = 0; endereco_desvio = '0; endereco_salto = '0;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_model(tag);
        $display("cyc %s hab=%0b exc=%0b rexc=%0b ret=%0b cal=%0b jmp=%0b br=%0b -> pc=%0d pc8=%0d epc=%0d",
                 tag, habilita, excecao, retorno_excecao, retorno, chamada, sel_salto, sel_desvio,
                 pc_a, pc_b, epc_a);
    endtask

    task automatic async_reset(input string tag);
        #2;
        pc_reset = 1;
        #1;
        model_reset();
        chk({tag, " async pc"},  32'(pc_a), 0);
        chk({tag, " async pc8"}, 32'(pc_b), 0);
        chk({tag, " async vaz"}, 32'(vaz_a), 1);
        $display("async reset %s -> pc=%0d", tag, pc_a);
        #1;
        pc_reset = 0;
    endtask

    typedef struct {
        logic        hab, exc, rexc, ret, cal, jmp, br;
        logic [W-1:0] a_s, a_d;
        logic [31:0] pc, epc;
        logic        emx, vaz, chei, err;
    } vec_t;

    vec_t tbl[25];

    initial begin
        // hab exc rexc ret cal jmp br  a_s  a_d   pc  epc emx vaz chei err
        tbl[0]  = '{1,0,0,0,0,1,0,   5,   0,   5,  0, 0, 1, 0, 0};
        tbl[1]  = '{1,0,0,0,1,0,0,  40,   0,  40,  0, 0, 0, 0, 0};
        tbl[2]  = '{1,0,0,1,0,0,0,   0,   0,   6,  0, 0, 1, 0, 0};
        tbl[3]  = '{1,0,0,0,0,1,0,  10,   0,  10,  0, 0, 1, 0, 0};
        tbl[4]  = '{1,0,0,0,1,0,0,  20,   0,  20,  0, 0, 0, 0, 0};
        tbl[5]  = '{1,0,0,0,1,0,0,  30,   0,  30,  0, 0, 0, 0, 0};
        tbl[6]  = '{1,0,0,0,1,0,0,  40,   0,  40,  0, 0, 0, 0, 0};
        tbl[7]  = '{1,0,0,0,1,0,0,  50,   0,  50,  0, 0, 0, 1, 0};
        tbl[8]  = '{1,0,0,0,1,0,0,  60,   0,  60,  0, 0, 0, 1, 1};
        tbl[9]  = '{1,0,0,1,0,0,0,   0,   0,  51,  0, 0, 0, 0, 1};
        tbl[10] = '{1,0,0,1,0,0,0,   0,   0,  41,  0, 0, 0, 0, 1};
        tbl[11] = '{1,0,0,1,0,0,0,   0,   0,  31,  0, 0, 0, 0, 1};
        tbl[12] = '{1,0,0,1,0,0,0,   0,   0,  21,  0, 0, 1, 0, 1};
        tbl[13] = '{1,0,0,1,0,0,0,   0,   0,  22,  0, 0, 1, 0, 1};
        tbl[14] = '{1,0,0,0,0,1,0,   7,   0,   7,  0, 0, 1, 0, 1};
        tbl[15] = '{0,1,0,0,0,0,0,   0,   0,   1,  7, 1, 1, 0, 1};
        tbl[16] = '{1,0,0,0,0,1,0,   3,   0,   3,  7, 1, 1, 0, 1};
        tbl[17] = '{1,1,0,0,0,0,0,   0,   0,   1,  7, 1, 1, 0, 1};
        tbl[18] = '{1,0,1,0,0,0,0,   0,   0,   7,  7, 0, 1, 0, 1};
        tbl[19] = '{1,0,0,0,0,1,1, 100, 200, 100,  7, 0, 1, 0, 1};
        tbl[20] = '{0,0,0,0,0,1,0, 300,   0, 100,  7, 0, 1, 0, 1};
        tbl[21] = '{1,0,0,0,0,1,0, 255,   0, 255,  7, 0, 1, 0, 1};
        tbl[22] = '{1,0,0,0,0,0,0,   0,   0, 256,  7, 0, 1, 0, 1};
        tbl[23] = '{1,0,0,0,0,1,0,   9,   0,   9,  7, 0, 1, 0, 1};
        tbl[24] = '{1,0,1,0,0,0,0,   0,   0,  10,  7, 0, 1, 0, 1};

        clear_inputs();
        pc_reset = 1;
        model_reset();
        #12;
        chk("reset pc",    32'(pc_a), 0);
        chk("reset epc",   32'(epc_a), 0);
        chk("reset emx",   32'(emx_a), 0);
        chk("reset vazia", 32'(vaz_a), 1);
        chk("reset cheia", 32'(chei_a), 0);
        chk("reset erro",  32'(err_a), 0);
        pc_reset = 0;

        // Free-running count, then an asynchronous reset between edges.
        for (int i = 1; i <= 3; i++) begin
            tick("seq");
            chk("seq pc", 32'(pc_a), 32'(i));
        end
        async_reset("mid");
        chk("after release pc", 32'(pc_a), 0);

        for (int i = 0; i < 25; i++) begin
            habilita = tbl[i].hab; excecao = tbl[i].exc; retorno_excecao = tbl[i].rexc;
            retorno = tbl[i].ret; chamada = tbl[i].cal; sel_salto = tbl[i].jmp;
            sel_desvio = tbl[i].br; endereco_salto = tbl[i].a_s; endereco_desvio = tbl[i].a_d;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d pc", i),    32'(pc_a), tbl[i].pc);
            chk($sformatf("vec%0d pc8", i),   32'(pc_b), tbl[i].pc & 32'hFF);
            chk($sformatf("vec%0d epc", i),   32'(epc_a), tbl[i].epc);
            chk($sformatf("vec%0d emx", i),   32'(emx_a), 32'(tbl[i].emx));
            chk($sformatf("vec%0d vazia", i), 32'(vaz_a), 32'(tbl[i].vaz));
            chk($sformatf("vec%0d cheia", i), 32'(chei_a), 32'(tbl[i].chei));
            chk($sformatf("vec%0d erro", i),  32'(err_a), 32'(tbl[i].err));
        end
        clear_inputs();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            habilita        = ($urandom_range(0, 7) != 0);
            excecao         = ($urandom_range(0, 15) == 0);
            retorno_excecao = ($urandom_range(0, 7) == 0);
            retorno         = ($urandom_range(0, 4) == 0);
            chamada         = ($urandom_range(0, 3) == 0);
            sel_salto       = ($urandom_range(0, 5) == 0);
            sel_desvio      = ($urandom_range(0, 3) == 0);
            endereco_salto  = W'($urandom);
            endereco_desvio = W'($urandom);
            if ($urandom_range(0, 3) == 0) endereco_salto = W'(MASK - 32'($urandom_range(0, 2)));
            tick($sformatf("rnd%0d", i));
            if ($urandom_range(0, 99) == 0) async_reset($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_de_programa_param.md
Name: contador_de_programa_param

Overview:
Parametrised successor to the fixed 26-bit program counter. Holds the current PC and selects the next PC from several sources: sequential increment, branch, jump, call/return through an internal return-address stack, exception vector, and return-from-exception through a saved EPC. Sits in the fetch stage, driving instruction-memory address. Adds stall, exception context and call-stack buffering, which the fixed-width PC lacks.

Parameters:
LARGURA, 26, PC/address width in bits
PASSO, 1, sequential increment (word-addressed memory)
VETOR_RESET, 0, PC value after reset
VETOR_EXCECAO, 1, PC loaded on exception entry
PROF_PILHA, 4, return-address stack depth (>=2, power of 2)

Ports:
clock  in  1  system clock, rising edge
pc_reset  in  1  asynchronous, active-high reset
habilita  in  1  1 = PC may advance; 0 = stall (hold)
sel_desvio  in  1  conditional branch taken
endereco_desvio  in  LARGURA  branch target
sel_salto  in  1  unconditional jump
chamada  in  1  call: push return address, jump to endereco_salto
retorno  in  1  return: pop stack into PC
endereco_salto  in  LARGURA  jump/call target
excecao  in  1  exception/interrupt request
retorno_excecao  in  1  return from exception
pcAtual  out  LARGURA  current PC (registered)
epc  out  LARGURA  saved exception PC (registered)
em_excecao  out  1  exception mode flag
pilha_vazia  out  1  stack count == 0
pilha_cheia  out  1  stack count == PROF_PILHA
erro_pilha  out  1  sticky: overflow or underflow occurred

Behaviour:
- Reset (async, any time incl. mid-operation): pcAtual=VETOR_RESET, epc=0, em_excecao=0, stack count=0, erro_pilha=0, pilha_vazia=1, pilha_cheia=0. Stack contents undefined.
- All state updates on rising clock; one-cycle latency: control sampled at edge N appears on pcAtual after edge N.
- seq = (pcAtual + PASSO) mod 2^LARGURA; wrap-around silent.
- Priority per edge, highest first; only one action taken:
  1. excecao=1 (acts even when habilita=0): pcAtual<=VETOR_EXCECAO; if em_excecao=0 then epc<=pcAtual and em_excecao<=1; if already 1, epc unchanged (no nesting).
  2. habilita=0: hold pcAtual, stack, epc, flags.
  3. retorno_excecao=1 and em_excecao=1: pcAtual<=epc, em_excecao<=0. If em_excecao=0: request ignored, fall through to lower priorities.
  4. retorno=1: if count>0, pcAtual<=top, count-1. If empty (underflow): pcAtual<=seq, erro_pilha<=1, count stays 0.
  5. chamada=1: push seq, pcAtual<=endereco_salto, count+1. If full (overflow): circular overwrite of oldest entry, count stays PROF_PILHA, erro_pilha<=1.
  6. sel_salto=1: pcAtual<=endereco_salto.
  7. sel_desvio=1: pcAtual<=endereco_desvio.
  8. else pcAtual<=seq.
- Stack: circular buffer with top pointer (log2 PROF_PILHA bits) plus count (log2 PROF_PILHA +1 bits); push writes at top+1, pop reads top; pointers wrap mod PROF_PILHA.
- Lower-priority requests in the same cycle are discarded, not queued.
- erro_pilha clears only on reset. pilha_vazia/pilha_cheia are derived combinationally from registered count.

Test Plan:
1. Reset then habilita=1 for 3 cycles, no controls -> pcAtual 0,1,2,3; assert pc_reset mid-cycle -> pcAtual=0 immediately, before next edge.
2. pcAtual=5, chamada with endereco_salto=40 -> pcAtual=40, pilha_vazia=0; next retorno -> pcAtual=6, pilha_vazia=1.
3. Five nested chamada (PROF_PILHA=4) from PCs 10,20,30,40,50 -> pilha_cheia=1, erro_pilha=1; four retorno -> 51,41,31,21; fifth retorno -> seq, erro_pilha stays 1.
4. pcAtual=7, habilita=0, excecao=1 -> pcAtual=1, epc=7, em_excecao=1; second excecao at PC 3 -> epc still 7; retorno_excecao -> pcAtual=7, em_excecao=0.
5. Same edge sel_salto=1 (target 100) and sel_desvio=1 (target 200) -> pcAtual=100; habilita=0 with sel_salto -> PC held.
6. LARGURA=8, pcAtual=255, sequential step -> pcAtual=0; retorno_excecao with em_excecao=0 at PC 9 -> pcAtual=10, epc unchanged.
